// File: rtl/predicate_writeback_scheduler_pkg.sv
// ============================================================================
// Module : predicate_writeback_scheduler_pkg
// Brief  : Default sizing and pointer helper for the predicate writeback scheduler
// Rev    : 1.0
// ============================================================================
`default_nettype none

package predicate_writeback_scheduler_pkg;

    localparam int unsigned c_DEF_REG_BITS = 2;
    localparam int unsigned c_DEF_NUM_REQ  = 3;
    localparam int unsigned c_DEF_CNT_BITS = 2;

    // Round-robin successor of a granted index, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/predicate_writeback_scheduler_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin search starting at a pointer, one-hot grant
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    always_comb begin
        int unsigned v_cand;
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        v_cand = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            v_cand = (int'(i_ptr) + off) % NUM_REQ;
            if (!o_any && i_req[v_cand]) begin
                o_any         = 1'b1;
                o_gnt[v_cand] = 1'b1;
                o_idx         = IDX_W'(v_cand);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/predicate_writeback_scheduler.sv
// ============================================================================
// Module : predicate_writeback_scheduler
// Brief  : Round-robin share of the predicate file write port plus pending-write scoreboard
// Rev    : 1.0
// ============================================================================
`default_nettype none

module predicate_writeback_scheduler
    import predicate_writeback_scheduler_pkg::*;
#(
    parameter int unsigned REG_BITS = c_DEF_REG_BITS,
    parameter int unsigned NUM_REQ  = c_DEF_NUM_REQ,
    parameter int unsigned CNT_BITS = c_DEF_CNT_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*REG_BITS-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]           req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         set_en,
    input  logic [REG_BITS-1:0]          set_addr,
    output logic                         set_ready,
    input  logic                         flush,
    input  logic [REG_BITS-1:0]          rd_addr1,
    input  logic [REG_BITS-1:0]          rd_addr2,
    input  logic [REG_BITS-1:0]          rd_addr3,
    output logic                         hazard1,
    output logic                         hazard2,
    output logic                         hazard3,
    output logic                         wr_en,
    output logic [REG_BITS-1:0]          wr_addr,
    output logic                         wr_data,
    output logic                         err_underflow
);

    localparam int unsigned         c_NUM_REG = 1 << REG_BITS;
    localparam int unsigned         c_IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_BITS-1:0] c_CNT_MAX = '1;

    logic [NUM_REQ-1:0]  w_req_elig;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [c_IDX_W-1:0]  w_gnt_idx;
    logic                w_accept;
    logic [REG_BITS-1:0] w_sel_addr;
    logic                w_sel_data;
    logic                w_set_fire;
    logic [c_NUM_REG-1:0] w_inc;
    logic [c_NUM_REG-1:0] w_dec;
    logic [c_NUM_REG-1:0] w_uf;

    logic [c_IDX_W-1:0]  r_rr_ptr;
    logic                r_wr_en;
    logic [REG_BITS-1:0] r_wr_addr;
    logic                r_wr_data;
    logic                r_err;
    logic [CNT_BITS-1:0] r_cnt [c_NUM_REG];

    // Nothing may be granted while held in reset or during a flush.
    assign w_req_elig = (reset && !flush) ? req_valid : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_arb (
        .i_req (w_req_elig),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_accept)
    );

    assign req_ready = w_gnt;

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = 1'b0;
        for (int unsigned g = 0; g < NUM_REQ; g++) begin
            if (w_gnt[g]) begin
                w_sel_addr = req_addr[g*REG_BITS +: REG_BITS];
                w_sel_data = req_data[g];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= c_IDX_W'(rr_next(int'(w_gnt_idx), NUM_REQ));
        end
    end

    // Address/data hold when idle so the file sees a stable bus.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
            end
        end
    end

    assign set_ready  = (r_cnt[set_addr] != c_CNT_MAX);
    assign w_set_fire = set_en && set_ready && !flush;

    for (genvar p = 0; p < c_NUM_REG; p++) begin : g_sb
        assign w_inc[p] = w_set_fire && (set_addr == REG_BITS'(p));
        assign w_dec[p] = r_wr_en && (r_wr_addr == REG_BITS'(p));
        assign w_uf[p]  = w_dec[p] && (r_cnt[p] == '0) && !flush;
    end

    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < c_NUM_REG; p++) begin
            if (!reset || flush) begin
                r_cnt[p] <= '0;
            end else if (w_inc[p] && !w_dec[p]) begin
                r_cnt[p] <= r_cnt[p] + CNT_BITS'(1);
            end else if (w_dec[p] && !w_inc[p] && (r_cnt[p] != '0)) begin
                r_cnt[p] <= r_cnt[p] - CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (|w_uf) begin
            r_err <= 1'b1;
        end
    end

    assign hazard1       = (r_cnt[rd_addr1] != '0);
    assign hazard2       = (r_cnt[rd_addr2] != '0);
    assign hazard3       = (r_cnt[rd_addr3] != '0);
    assign wr_en         = r_wr_en;
    assign wr_addr       = r_wr_addr;
    assign wr_data       = r_wr_data;
    assign err_underflow = r_err;

endmodule

`default_nettype wire

// File: tb/tb_predicate_writeback_scheduler.sv
// ============================================================================
// Module : tb_predicate_writeback_scheduler
// Brief  : Directed self-checking bench for the predicate writeback scheduler
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_predicate_writeback_scheduler;

    logic       clk;
    logic       reset;
    logic [2:0] req_valid;
    logic [5:0] req_addr;
    logic [2:0] req_data;
    logic [2:0] req_ready;
    logic       set_en;
    logic [1:0] set_addr;
    logic       set_ready;
    logic       flush;
    logic [1:0] rd_addr1, rd_addr2, rd_addr3;
    logic       hazard1, hazard2, hazard3;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic       wr_data;
    logic       err_underflow;

    int checks = 0;
    int errors = 0;
    int exp_addr [3] = '{1, 2, 3};
    int exp_data [3] = '{1, 0, 1};

    predicate_writeback_scheduler #(
        .REG_BITS (2),
        .NUM_REQ  (3),
        .CNT_BITS (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .set_en        (set_en),
        .set_addr      (set_addr),
        .set_ready     (set_ready),
        .flush         (flush),
        .rd_addr1      (rd_addr1),
        .rd_addr2      (rd_addr2),
        .rd_addr3      (rd_addr3),
        .hazard1       (hazard1),
        .hazard2       (hazard2),
        .hazard3       (hazard3),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 3'b111;
        req_addr  = 6'b11_10_01;
        req_data  = 3'b101;
        set_en    = 1'b0;
        set_addr  = 2'd0;
        flush     = 1'b0;
        rd_addr1  = 2'd1;
        rd_addr2  = 2'd2;
        rd_addr3  = 2'd3;

        // Reset held two cycles with every requester asking.
        tick();
        tick();
        chk("rst_ready", req_ready, 3'b000);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, 2'd0);
        chk("rst_hazards", {hazard1, hazard2, hazard3}, 3'b000);
        chk("rst_err", err_underflow, 1'b0);

        // Preload two pending writes on each of predicates 1..3.
        reset     = 1'b1;
        req_valid = 3'b000;
        for (int a = 1; a <= 3; a++) begin
            for (int k = 0; k < 2; k++) begin
                set_en   = 1'b1;
                set_addr = 2'(a);
                #1;
                chk("pre_set_ready", set_ready, 1'b1);
                tick();
            end
        end
        set_en = 1'b0;
        #1;
        chk("pre_hazards", {hazard1, hazard2, hazard3}, 3'b111);

        // Rotating grants with all three requesters valid.
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_grant", req_ready, 32'(1 << (i % 3)));
            tick();
            chk("rr_wr_en", wr_en, 1'b1);
            chk("rr_wr_addr", wr_addr, 32'(exp_addr[i % 3]));
            chk("rr_wr_data", wr_data, 32'(exp_data[i % 3]));
        end
        req_valid = 3'b000;
        tick();
        chk("rr_idle_wr_en", wr_en, 1'b0);
        chk("rr_idle_addr_hold", wr_addr, 2'd3);
        chk("rr_drained_hazards", {hazard1, hazard2, hazard3}, 3'b000);
        chk("rr_no_err", err_underflow, 1'b0);

        // Single producer on predicate 2, retired three cycles later by req0.
        rd_addr1 = 2'd2;
        set_en   = 1'b1;
        set_addr = 2'd2;
        #1;
        chk("h_c0", hazard1, 1'b0);
        tick();
        set_en = 1'b0;
        chk("h_c1", hazard1, 1'b1);
        tick();
        chk("h_c2", hazard1, 1'b1);
        tick();
        req_valid = 3'b001;
        req_addr  = 6'b11_10_10;
        req_data  = 3'b001;
        #1;
        chk("h_c3", hazard1, 1'b1);
        chk("h_c3_grant", req_ready, 3'b001);
        tick();
        req_valid = 3'b000;
        chk("h_c4_hazard", hazard1, 1'b1);
        chk("h_c4_wr", {wr_en, wr_addr, wr_data}, {1'b1, 2'd2, 1'b1});
        tick();
        chk("h_c5_hazard", hazard1, 1'b0);
        chk("h_c5_wr_en", wr_en, 1'b0);

        // Saturate predicate 1 at three pending writes; pointer now at 1.
        rd_addr1 = 2'd1;
        set_addr = 2'd1;
        for (int k = 0; k < 3; k++) begin
            set_en = 1'b1;
            #1;
            chk("sat_set_ready", set_ready, 1'b1);
            tick();
        end
        chk("sat_full", set_ready, 1'b0);
        tick();
        set_en    = 1'b0;
        req_valid = 3'b010;
        req_addr  = 6'b01_01_01;
        #1;
        chk("sat_grant1", req_ready, 3'b010);
        tick();
        req_valid = 3'b000;
        chk("sat_retire_no_bypass", set_ready, 1'b0);
        chk("sat_retire_wr", {wr_en, wr_addr}, {1'b1, 2'd1});
        tick();
        chk("sat_cnt2_ready", set_ready, 1'b1);
        chk("sat_cnt2_hazard", hazard1, 1'b1);
        req_valid = 3'b100;
        #1;
        chk("sat_grant2", req_ready, 3'b100);
        tick();
        // Set and retire on predicate 1 in the same cycle.
        req_valid = 3'b000;
        set_en    = 1'b1;
        #1;
        chk("sim_set_ready", set_ready, 1'b1);
        chk("sim_wr_en", wr_en, 1'b1);
        tick();
        set_en    = 1'b0;
        req_valid = 3'b001;
        #1;
        chk("sim_hazard", hazard1, 1'b1);
        chk("sim_grant0", req_ready, 3'b001);
        tick();
        req_valid = 3'b010;
        #1;
        chk("sim_grant1", req_ready, 3'b010);
        tick();
        req_valid = 3'b000;
        chk("sim_cnt1_hazard", hazard1, 1'b1);
        tick();
        chk("sim_cnt0_hazard", hazard1, 1'b0);
        chk("sim_wr_en_idle", wr_en, 1'b0);
        chk("sim_no_err", err_underflow, 1'b0);

        // Flush with a write to predicate 0 already in the output stage; pointer at 2.
        rd_addr1 = 2'd0;
        set_addr = 2'd0;
        set_en   = 1'b1;
        tick();
        tick();
        set_en    = 1'b0;
        req_valid = 3'b100;
        req_addr  = 6'b00_00_00;
        #1;
        chk("fl_grant", req_ready, 3'b100);
        tick();
        flush     = 1'b1;
        req_valid = 3'b111;
        #1;
        chk("fl_ready_blocked", req_ready, 3'b000);
        chk("fl_wr_in_stage", {wr_en, wr_addr}, {1'b1, 2'd0});
        chk("fl_hazard_before", hazard1, 1'b1);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_hazard_cleared", {hazard1, hazard2, hazard3}, 3'b000);
        chk("fl_no_new_write", wr_en, 1'b0);
        chk("fl_no_err", err_underflow, 1'b0);
        chk("fl_ptr_held", req_ready, 3'b001);
        req_valid = 3'b000;
        set_en    = 1'b1;
        set_addr  = 2'd3;
        #1;
        chk("fl_set_ready", set_ready, 1'b1);
        set_en = 1'b0;
        #1;

        // Retire of predicate 3 with nothing pending raises the sticky error.
        req_valid = 3'b001;
        req_addr  = 6'b00_00_11;
        #1;
        chk("uf_grant", req_ready, 3'b001);
        tick();
        req_valid = 3'b000;
        chk("uf_retire", {wr_en, wr_addr}, {1'b1, 2'd3});
        chk("uf_not_yet", err_underflow, 1'b0);
        tick();
        chk("uf_set", err_underflow, 1'b1);
        tick();
        tick();
        chk("uf_sticky", err_underflow, 1'b1);
        reset     = 1'b0;
        req_valid = 3'b111;
        #1;
        chk("uf_rst_ready", req_ready, 3'b000);
        tick();
        chk("uf_rst_err", err_underflow, 1'b0);
        chk("uf_rst_wr_en", wr_en, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
